burst_write_engine: RTL
=======================

Name: burst_write_engine

Overview:
- Parametrised next-generation burst write pipeline.
- Accepts one burst command (start address, length, burst type) and a stream of data beats with byte strobes.
- Issues one registered write per beat to a back-pressurable memory write port.
- Returns one response per burst (not per beat) through a response FIFO. Sits between an upstream write master and a memory/slave write port.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; power of two, at least 8.
- ADDR_WIDTH, 32, byte address width.
- MAX_BURST_LENGTH, 16, maximum beats per burst; range 1..256.
- RESP_DEPTH, 4, response FIFO depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- u_addr  in  ADDR_WIDTH  burst start byte address
- u_length  in  8  beats-1
- u_burst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- u_addr_valid  in  1  command valid
- u_addr_ready  out  1  command ready
- u_data  in  DATA_WIDTH  beat data
- u_strb  in  DATA_WIDTH/8  byte strobes
- u_data_valid  in  1  beat valid
- u_data_ready  out  1  beat ready
- m_addr  out  ADDR_WIDTH  write address
- m_data  out  DATA_WIDTH  write data
- m_strb  out  DATA_WIDTH/8  write strobes
- m_valid  out  1  write valid
- m_last  out  1  final beat of burst
- m_ready  in  1  write accepted
- d_resp  out  2  response code: 00 OKAY, 10 SLVERR
- d_resp_addr  out  ADDR_WIDTH  start address of the completed burst
- d_valid  out  1  response valid
- d_ready  in  1  response ready

Behaviour:
- Reset: asynchronous, active-high, clears all state.
  - State machine goes to IDLE.
  - m_valid, m_last, d_valid, u_data_ready go to 0; u_addr_ready reflects IDLE with free credits after reset.
  - m_addr, m_data, m_strb, d_resp, d_resp_addr go to 0.
  - FIFO and outstanding counter are cleared.
  - Reset mid-burst discards the partial burst; no response is generated for it.
- State machine: IDLE, BURST.
- Command accept:
  - fire = u_addr_valid && u_addr_ready.
  - u_addr_ready = credit_ok && (IDLE, or BURST with the final beat firing this cycle). This allows back-to-back bursts with no bubble.
  - credit_ok = fifo_count + outstanding < RESP_DEPTH.
  - outstanding increments on command fire and decrements on response push; net 0 when both happen in one cycle.
- Error check, evaluated at command fire and latched as err. SLVERR if any of:
  - u_length+1 > MAX_BURST_LENGTH;
  - u_addr not aligned to BYTES = DATA_WIDTH/8;
  - u_burst == 3;
  - WRAP with u_length not in {1, 3, 7, 15}.
- Beat handshake:
  - u_data_ready = BURST && (!m_valid || m_ready).
  - beat = u_data_valid && u_data_ready.
  - Each beat loads the output register: m_addr = current address, m_data = u_data, m_strb = err ? 0 : u_strb, m_last = (count == 0), m_valid = 1.
  - Error bursts still consume every beat and still present no-op writes (strobes 0), so responses stay in order.
- Output register:
  - Holds its contents while m_valid && !m_ready.
  - Clears m_valid on accept when no new beat loads in the same cycle.
- Beat counter: loads u_length at command fire and decrements per beat. The last beat is at count == 0; the state then goes to IDLE, or reloads for a new command firing in the same cycle.
- Address update per beat:
  - FIXED: unchanged.
  - INCR: +BYTES, wrapping modulo 2^ADDR_WIDTH.
  - WRAP: size = (len+1)*BYTES, base = addr & ~(size-1); next = base | ((addr+BYTES) & (size-1)).
- Response push: on m_valid && m_ready && m_last, push {err ? 10 : 00, start address} stored alongside the beat. A full FIFO never occurs at push, because of the credit check.
- Response FIFO:
  - First-word-fall-through; d_valid = !empty.
  - Pop on d_valid && d_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - Pointers wrap modulo RESP_DEPTH.
- Latency: beat to m_valid is 1 cycle; last beat accepted by m_ready to d_valid is 1 cycle.

Test Plan:
- INCR, addr 0x100, len 3, all strobes 0xF, m_ready=1 -> m_addr 0x100, 0x104, 0x108, 0x10C; m_last on 4th beat only; one response, d_resp 00, d_resp_addr 0x100.
- WRAP, addr 0x38, len 3 -> m_addr 0x38, 0x30, 0x34, 0x38 is wrong; required sequence 0x38, 0x3C, 0x30, 0x34; d_resp 00.
- Error bursts:
  - len 16 with MAX_BURST_LENGTH 16 -> all 17 beats consumed, m_strb 0 on every beat, d_resp 10.
  - addr 0x102 -> SLVERR, strobes 0.
- Back-pressure:
  - m_ready held low for 5 cycles mid-burst -> m_* stable, u_data_ready 0.
  - d_ready=0 with RESP_DEPTH 4 -> the 5th command is not accepted until one response pops.
- Back-to-back: two FIXED bursts at 0x40 and 0x80, len 1, u_addr_valid held -> 2nd command accepted in the cycle of the 1st burst's last beat; no idle cycle; responses in order.
- Reset asserted mid-burst after 2 of 4 beats -> outputs 0 immediately; no response; next burst after deassertion completes normally.

Source files
------------

// File: rtl/burst_write_engine.sv
// rtl/burst_write_engine.sv - burst write pipeline: one command plus N beats in, registered writes out, one response per burst
// Responses queue in a small FWFT FIFO; credits bound commands in flight so the FIFO never overflows.
module burst_write_engine #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int MAX_BURST_LENGTH = 16,
   parameter int RESP_DEPTH       = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   u_addr,
   input  logic [7:0]              u_length,
   input  logic [1:0]              u_burst,
   input  logic                    u_addr_valid,
   output logic                    u_addr_ready,
   input  logic [DATA_WIDTH-1:0]   u_data,
   input  logic [DATA_WIDTH/8-1:0] u_strb,
   input  logic                    u_data_valid,
   output logic                    u_data_ready,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic [DATA_WIDTH/8-1:0] m_strb,
   output logic                    m_valid,
   output logic                    m_last,
   input  logic                    m_ready,
   output logic [1:0]              d_resp,
   output logic [ADDR_WIDTH-1:0]   d_resp_addr,
   output logic                    d_valid,
   input  logic                    d_ready
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t                  state;
   logic [7:0]              count;
   logic [7:0]              len_q;
   logic [1:0]              burst_q;
   logic                    err_q;
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic [ADDR_WIDTH-1:0]   start_addr;
   logic                    m_err;
   logic [ADDR_WIDTH-1:0]   m_start;
   logic [CNT_W-1:0]        outstanding;

   logic [CNT_W-1:0]        fifo_count;
   logic [PTR_W-1:0]        wptr;
   logic [PTR_W-1:0]        rptr;
   logic [1:0]              fifo_resp [RESP_DEPTH];
   logic [ADDR_WIDTH-1:0]   fifo_addr [RESP_DEPTH];

   logic                    credit_ok;
   logic                    beat;
   logic                    last_beat;
   logic                    fire;
   logic                    push;
   logic                    pop;
   logic                    len_err;
   logic                    align_err;
   logic                    wrap_err;
   logic                    cmd_err;
   logic [ADDR_WIDTH-1:0]   wrap_size;
   logic [ADDR_WIDTH-1:0]   incr_addr;
   logic [ADDR_WIDTH-1:0]   next_addr;

   assign credit_ok    = (SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(RESP_DEPTH);
   assign u_data_ready = (state == BURST) && (!m_valid || m_ready);
   assign beat         = u_data_valid && u_data_ready;
   assign last_beat    = beat && (count == 8'd0);
   // Accepting during the final beat lets the next burst start with no bubble.
   assign u_addr_ready = credit_ok && ((state == IDLE) || last_beat);
   assign fire         = u_addr_valid && u_addr_ready;
   assign push         = m_valid && m_ready && m_last;
   assign pop          = d_valid && d_ready;

   assign len_err   = (9'(u_length) + 9'd1) > 9'(MAX_BURST_LENGTH);
   assign align_err = (u_addr & ADDR_WIDTH'(BYTES - 1)) != '0;
   assign wrap_err  = (u_burst == 2'd2) &&
                      !((u_length == 8'd1) || (u_length == 8'd3) ||
                        (u_length == 8'd7) || (u_length == 8'd15));
   assign cmd_err   = len_err || align_err || (u_burst == 2'd3) || wrap_err;

   always_comb begin
      wrap_size = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) * ADDR_WIDTH'(BYTES);
      incr_addr = cur_addr + ADDR_WIDTH'(BYTES);
      next_addr = cur_addr;
      case (burst_q)
         2'd1:    next_addr = incr_addr;
         2'd2:    next_addr = (cur_addr & ~(wrap_size - ADDR_WIDTH'(1))) |
                              (incr_addr & (wrap_size - ADDR_WIDTH'(1)));
         default: next_addr = cur_addr;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         len_q       <= '0;
         burst_q     <= '0;
         err_q       <= 1'b0;
         cur_addr    <= '0;
         start_addr  <= '0;
         m_addr      <= '0;
         m_data      <= '0;
         m_strb      <= '0;
         m_valid     <= 1'b0;
         m_last      <= 1'b0;
         m_err       <= 1'b0;
         m_start     <= '0;
         outstanding <= '0;
      end else begin
         // Error bursts still emit every beat, with strobes forced off, to keep responses ordered.
         if (beat) begin
            m_addr   <= cur_addr;
            m_data   <= u_data;
            m_strb   <= err_q ? '0 : u_strb;
            m_last   <= (count == 8'd0);
            m_valid  <= 1'b1;
            m_err    <= err_q;
            m_start  <= start_addr;
            cur_addr <= next_addr;
            count    <= count - 8'd1;
         end else if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end

         if (fire) begin
            cur_addr   <= u_addr;
            start_addr <= u_addr;
            count      <= u_length;
            len_q      <= u_length;
            burst_q    <= u_burst;
            err_q      <= cmd_err;
            state      <= BURST;
         end else if (last_beat) begin
            state <= IDLE;
         end

         case ({fire, push})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         for (int i = 0; i < RESP_DEPTH; i++) begin
            fifo_resp[i] <= '0;
            fifo_addr[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_resp[wptr] <= m_err ? 2'b10 : 2'b00;
            fifo_addr[wptr] <= m_start;
            wptr            <= wptr + PTR_W'(1);
         end
         if (pop) begin
            rptr <= rptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign d_valid     = (fifo_count != '0);
   assign d_resp      = fifo_resp[rptr];
   assign d_resp_addr = fifo_addr[rptr];

endmodule
